// File: rtl/aibio_dll_ctrl_pkg.sv
// Shared types and widths for the DLL bring-up / lock supervisor.
package aibio_dll_ctrl_pkg;

  localparam int CAP_W    = 5;
  localparam int RELOCK_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } dll_ctrl_state_e;

  // Largest of the three cycle parameters; sizes the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/aibio_dll_lock_sync.sv
// Two-flop synchroniser for the asynchronous lock-detector flag.
module aibio_dll_lock_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the async input through two flops; clear both on reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/aibio_dll_lock_ctrl.sv
// DLL bring-up and lock supervisor: enable/reset the DLL, sweep the cap
// code until lock, then watch for loss of lock and relock automatically.
module aibio_dll_lock_ctrl
  import aibio_dll_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOSS_CYCLES   = 64,
  parameter int CAP_START     = 0,
  parameter int CAP_MAX       = 31
) (
  input  logic             i_clkin,
  input  logic             i_reset,
  input  logic             i_pwrgood,
  input  logic             i_cal_start,
  input  logic             i_bypass,
  input  logic [CAP_W-1:0] i_cap_override,
  input  logic             i_dll_lock,
  output logic             o_dll_en,
  output logic             o_dll_reset,
  output logic [CAP_W-1:0] o_dll_capctrl,
  output logic             o_cal_done,
  output logic             o_cal_fail,
  output logic [3:0]       o_relock_cnt,
  output logic [2:0]       o_state
);

  localparam int MAXC  = max3(RESET_CYCLES, SETTLE_CYCLES, LOSS_CYCLES);
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  // Counter reload values: the counter expires on the cycle it reads zero,
  // so loading N-1 gives exactly N cycles in the state.
  localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LD   = CNT_W'(LOSS_CYCLES - 1);
  localparam logic [CAP_W-1:0] CAP_LO    = CAP_W'(CAP_START);
  localparam logic [CAP_W-1:0] CAP_HI    = CAP_W'(CAP_MAX);

  dll_ctrl_state_e       r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_en;
  logic                  r_rst;
  logic [CAP_W-1:0]      r_cap;
  logic                  r_done;
  logic                  r_fail;
  logic [RELOCK_W-1:0]   r_relock;
  logic                  w_lock_s;
  logic [CAP_W-1:0]      w_sweep_start;

  aibio_dll_lock_sync u_lock_sync (
    .i_clk   (i_clkin),
    .i_reset (i_reset),
    .i_d     (i_dll_lock),
    .o_q     (w_lock_s)
  );

  // First code of every sweep, whether from IDLE or after a loss of lock.
  assign w_sweep_start = i_bypass ? i_cap_override : CAP_LO;

  // Main supervisor FSM; all outputs registered alongside the state.
  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_en     <= 1'b0;
      r_rst    <= 1'b1;
      r_cap    <= CAP_LO;
      r_done   <= 1'b0;
      r_fail   <= 1'b0;
      r_relock <= '0;
    end else if (!i_pwrgood || !i_cal_start) begin
      // Abort: park the DLL, but keep cap code and relock count for DFX.
      r_state <= ST_IDLE;
      r_en    <= 1'b0;
      r_rst   <= 1'b1;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state  <= ST_RST;
          r_en     <= 1'b1;
          r_rst    <= 1'b1;
          r_cap    <= w_sweep_start;
          r_relock <= '0;
          r_cnt    <= RST_LD;
        end
        ST_RST: begin
          if (r_cnt == '0) begin
            r_state <= ST_SETTLE;
            r_rst   <= 1'b0;
            r_cnt   <= SETTLE_LD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) r_state <= ST_CHECK;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_CHECK: begin
          if (w_lock_s) begin
            r_state <= ST_LOCKED;
            r_done  <= 1'b1;
            r_cnt   <= LOSS_LD;
          end else if (i_bypass || r_cap == CAP_HI) begin
            // Bypass gets one attempt only; a sweep never wraps.
            r_state <= ST_FAIL;
            r_fail  <= 1'b1;
          end else begin
            r_state <= ST_RST;
            r_rst   <= 1'b1;
            r_cap   <= r_cap + 1'b1;
            r_cnt   <= RST_LD;
          end
        end
        ST_LOCKED: begin
          if (w_lock_s) begin
            r_cnt <= LOSS_LD;
          end else if (r_cnt == '0) begin
            r_state <= ST_RST;
            r_done  <= 1'b0;
            r_rst   <= 1'b1;
            r_cap   <= w_sweep_start;
            r_cnt   <= RST_LD;
            if (r_relock != '1) r_relock <= r_relock + 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_FAIL: begin
          r_state <= ST_FAIL;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_dll_en      = r_en;
  assign o_dll_reset   = r_rst;
  assign o_dll_capctrl = r_cap;
  assign o_cal_done    = r_done;
  assign o_cal_fail    = r_fail;
  assign o_relock_cnt  = r_relock;
  assign o_state       = r_state;

endmodule

// File: tb/tb_aibio_dll_lock_ctrl.sv
// Scoreboard bench for the DLL lock supervisor. A timeline model predicts
// every output change (cycle and values); a monitor pops and compares on
// each change the DUT actually makes.
module tb_aibio_dll_lock_ctrl;

  localparam int R  = 4;
  localparam int S  = 8;
  localparam int L  = 4;
  localparam int CS = 0;
  localparam int CM = 31;

  logic       clk = 1'b0;
  logic       i_reset, i_pwrgood, i_cal_start, i_bypass, i_dll_lock;
  logic [4:0] i_cap_override;
  logic       o_dll_en, o_dll_reset, o_cal_done, o_cal_fail;
  logic [4:0] o_dll_capctrl;
  logic [3:0] o_relock_cnt;
  logic [2:0] o_state;

  aibio_dll_lock_ctrl #(
    .RESET_CYCLES(R), .SETTLE_CYCLES(S), .LOSS_CYCLES(L),
    .CAP_START(CS), .CAP_MAX(CM)
  ) dut (
    .i_clkin(clk), .i_reset(i_reset), .i_pwrgood(i_pwrgood),
    .i_cal_start(i_cal_start), .i_bypass(i_bypass),
    .i_cap_override(i_cap_override), .i_dll_lock(i_dll_lock),
    .o_dll_en(o_dll_en), .o_dll_reset(o_dll_reset),
    .o_dll_capctrl(o_dll_capctrl), .o_cal_done(o_cal_done),
    .o_cal_fail(o_cal_fail), .o_relock_cnt(o_relock_cnt), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DLL behaviour: locks once enabled, out of reset, at a code >= target.
  int tgt_code = 0;
  bit force_drop = 1'b0;
  assign i_dll_lock = o_dll_en && !o_dll_reset &&
                      (int'(o_dll_capctrl) >= tgt_code) && !force_drop;

  typedef struct packed {
    logic [31:0] t;
    logic [2:0]  st;
    logic        en;
    logic        rs;
    logic [4:0]  cap;
    logic        dn;
    logic        fl;
    logic [3:0]  rc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  m_cap = CS;
  int  m_relock = 0;
  int  m_first = CS;
  bit  mon_en = 1'b0;
  int  rst_entries = 0;

  task automatic push_ev(input int t, input int st, input bit en, input bit rs,
                         input bit dn, input bit fl);
    ev_t e;
    e.t = t; e.st = st[2:0]; e.en = en; e.rs = rs; e.cap = m_cap[4:0];
    e.dn = dn; e.fl = fl; e.rc = m_relock[3:0];
    exp_q.push_back(e);
  endtask

  // One calibration run: each attempt is RST for R, SETTLE for S, CHECK for 1.
  task automatic model_sweep(input int t0, input int first, input bit byp,
                             input int tgt, output int tend, output bit locked);
    int t; int code; bit fin;
    t = t0; code = first; fin = 0; locked = 0;
    while (!fin) begin
      m_cap = code;
      push_ev(t, 1, 1, 1, 0, 0);
      push_ev(t + R, 2, 1, 0, 0, 0);
      push_ev(t + R + S, 3, 1, 0, 0, 0);
      t = t + R + S + 1;
      if (code >= tgt) begin
        push_ev(t, 4, 1, 0, 1, 0); locked = 1; fin = 1;
      end else if (byp || code == CM) begin
        push_ev(t, 5, 1, 0, 0, 1); fin = 1;
      end else begin
        code++;
      end
    end
    tend = t;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic start_cal(input bit byp, input int ovr, input int tgt,
                           input bit wait_end, output bit locked);
    int tend;
    tgt_code = tgt; i_bypass = byp; i_cap_override = ovr[4:0];
    i_pwrgood = 1; i_cal_start = 1;
    m_relock = 0;
    m_first = byp ? ovr : CS;
    model_sweep(cyc + 1, m_first, byp, tgt, tend, locked);
    if (wait_end) wait_until(tend + 1);
  endtask

  // Leaving a non-IDLE state: park outputs, keep cap and relock count.
  task automatic stop_cal();
    i_cal_start = 0;
    push_ev(cyc + 1, 0, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
  endtask

  // Lock drop of d cycles while LOCKED; d == L triggers a relock.
  task automatic drop_lock(input int d);
    int n; int tend; bit lk;
    n = cyc;
    if (d >= L) begin
      m_relock = (m_relock < 15) ? m_relock + 1 : 15;
      model_sweep(n + 2 + L, m_first, i_bypass, tgt_code, tend, lk);
    end
    force_drop = 1;
    repeat (d) @(negedge clk);
    force_drop = 0;
    if (d >= L) wait_until(tend + 1);
    else repeat (4) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output change must match the next predicted event.
  logic [15:0] prev_sig;
  always @(negedge clk) begin
    logic [15:0] cur_sig;
    ev_t cur, e;
    cur_sig = {o_state, o_dll_en, o_dll_reset, o_dll_capctrl, o_cal_done,
               o_cal_fail, o_relock_cnt};
    if (mon_en && cur_sig != prev_sig) begin
      if (o_state == 3'd1 && prev_sig[15:13] != 3'd1) rst_entries++;
      cur = {cyc[31:0], cur_sig};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cyc=%0d state=%0d cap=%0d", cyc,
                 o_state, o_dll_capctrl);
      end else begin
        e = exp_q.pop_front();
        if (e != cur) begin
          errors++;
          $display("FAIL event: got t=%0d st=%0d en=%0b rs=%0b cap=%0d dn=%0b fl=%0b rc=%0d expected t=%0d st=%0d en=%0b rs=%0b cap=%0d dn=%0b fl=%0b rc=%0d",
                   cur.t, cur.st, cur.en, cur.rs, cur.cap, cur.dn, cur.fl, cur.rc,
                   e.t, e.st, e.en, e.rs, e.cap, e.dn, e.fl, e.rc);
        end
      end
    end
    prev_sig = cur_sig;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit lk;
    int n, base;
    i_reset = 1; i_pwrgood = 1; i_cal_start = 0; i_bypass = 0;
    i_cap_override = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(o_state), 0);
    chk("reset_en", int'(o_dll_en), 0);
    chk("reset_dllrst", int'(o_dll_reset), 1);
    chk("reset_cap", int'(o_dll_capctrl), CS);
    chk("reset_done_fail", int'({o_cal_done, o_cal_fail}), 0);
    chk("reset_relock", int'(o_relock_cnt), 0);
    i_reset = 0;
    @(negedge clk);
    mon_en = 1;

    // Nominal lock at the first code, then glitches and relocks.
    start_cal(0, 0, 0, 1, lk);
    chk("nominal_done", int'(o_cal_done), 1);
    for (int i = 0; i < 2; i++) drop_lock($urandom_range(1, L - 1));
    for (int i = 0; i < 16; i++) drop_lock(L);
    chk("relock_saturated", int'(o_relock_cnt), 15);
    stop_cal();

    // Sweep to code 7: eight reset pulses, then one loss and a reset mid-LOCKED.
    base = rst_entries;
    start_cal(0, 0, 7, 1, lk);
    chk("sweep7_cap", int'(o_dll_capctrl), 7);
    chk("sweep7_pulses", rst_entries - base, 8);
    drop_lock(L);
    n = cyc;
    i_reset = 1; i_cal_start = 0;
    m_cap = CS; m_relock = 0;
    push_ev(n + 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    i_reset = 0;
    repeat (2) @(negedge clk);

    // Randomised calibrations, optionally bypassed.
    for (int i = 0; i < 6; i++) begin
      start_cal($urandom_range(0, 1), $urandom_range(0, 31),
                $urandom_range(0, 12), 1, lk);
      if (lk && $urandom_range(0, 1) == 1) drop_lock($urandom_range(1, L - 1));
      stop_cal();
    end

    // Exhaustion: never locks, stops at CAP_MAX without wrapping.
    start_cal(0, 0, 32, 1, lk);
    chk("exhaust_fail", int'(o_cal_fail), 1);
    chk("exhaust_cap", int'(o_dll_capctrl), CM);
    stop_cal();
    chk("exhaust_abort_en", int'(o_dll_en), 0);

    // Bypass: lock at the override, and single-attempt fail.
    start_cal(1, 19, 10, 1, lk);
    chk("bypass_lock_cap", int'(o_dll_capctrl), 19);
    stop_cal();
    start_cal(1, 19, 25, 1, lk);
    chk("bypass_fail", int'(o_cal_fail), 1);
    stop_cal();

    // Power-good drop during SETTLE of a bypassed attempt.
    start_cal(1, $urandom_range(1, 31), 0, 0, lk);
    wait_until(cyc + R + 3);
    n = cyc;
    i_pwrgood = 0;
    while (exp_q.size() > 0 && int'(exp_q[$].t) > n) void'(exp_q.pop_back());
    m_cap = m_first;
    push_ev(n + 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    i_pwrgood = 1; i_cal_start = 0;
    chk("pwrgood_abort_rst", int'(o_dll_reset), 1);
    repeat (3) @(negedge clk);

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aibio_dll_lock_ctrl.md
Name: aibio_dll_lock_ctrl

Overview:
- Digital bring-up and lock supervisor for the TX/RX DLL macro, i.e. the controlling end of the DLL enable/reset/capctrl/lock interface.
- Enables and resets the DLL, then sweeps the delay-line cap code until the lock detector reports lock.
- Once locked, monitors for loss of lock and relocks automatically.
- Sits in the AIB IO digital wrapper beside the DLL CBB and is clocked by the system clock that also feeds the lock detector.

Parameters:
RESET_CYCLES, 16, cycles o_dll_reset is held high per attempt (>=2)
SETTLE_CYCLES, 1024, cycles allowed for DLL settling after reset release (>=2)
LOSS_CYCLES, 64, consecutive unlocked cycles in LOCKED that declare loss of lock (>=1)
CAP_START, 0, first capctrl code of a sweep
CAP_MAX, 31, last capctrl code of a sweep (CAP_START<=CAP_MAX<=31)

Ports:
i_clkin  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_pwrgood  in  1  supply good; low forces IDLE
i_cal_start  in  1  level; high requests/maintains calibration, low aborts to IDLE
i_bypass  in  1  use i_cap_override instead of sweeping
i_cap_override  in  5  fixed cap code when bypassed
i_dll_lock  in  1  asynchronous lock flag from lock detector
o_dll_en  out  1  DLL enable
o_dll_reset  out  1  DLL reset
o_dll_capctrl  out  5  delay-line cap code
o_cal_done  out  1  high while in LOCKED
o_cal_fail  out  1  high while in FAIL
o_relock_cnt  out  4  saturating count of loss-of-lock events
o_state  out  3  current state encoding for DFX view

Behaviour:
- Clock and reset: single clock i_clkin. i_reset is synchronous and active-high.
- Reset values: state IDLE, o_dll_en=0, o_dll_reset=1, o_dll_capctrl=CAP_START, o_cal_done=0, o_cal_fail=0, o_relock_cnt=0, sync flops=0.
- Lock synchronisation: i_dll_lock passes through a 2-flop synchroniser giving lock_s. All decisions use lock_s (2-cycle latency).
- Outputs: all registered. Output changes appear in the same cycle the state register changes.
- States and encodings: IDLE=0, RST=1, SETTLE=2, CHECK=3, LOCKED=4, FAIL=5.
- Global override (priority 1): i_pwrgood==0 or i_cal_start==0 in any state -> IDLE next cycle, with o_dll_en=0, o_dll_reset=1, done=0, fail=0. o_dll_capctrl and o_relock_cnt hold their values.
- IDLE: when i_pwrgood & i_cal_start -> RST. On that transition:
  - o_dll_capctrl loads i_cap_override if i_bypass, else CAP_START.
  - o_relock_cnt clears.
- RST: o_dll_en=1, o_dll_reset=1. After exactly RESET_CYCLES cycles in RST -> SETTLE.
- SETTLE: o_dll_reset=0. After exactly SETTLE_CYCLES cycles in SETTLE -> CHECK.
- CHECK: one cycle.
  - lock_s=1 -> LOCKED, o_cal_done=1.
  - Otherwise, if i_bypass or o_dll_capctrl==CAP_MAX -> FAIL, o_cal_fail=1. The cap code never wraps.
  - Otherwise o_dll_capctrl+1 -> RST.
- LOCKED: a loss counter counts consecutive cycles with lock_s=0 and clears on lock_s=1.
  - When it reaches LOSS_CYCLES: -> RST, o_cal_done=0, o_relock_cnt increments (saturates at 15).
  - The relock sweep restarts at CAP_START, or at i_cap_override if i_bypass.
- FAIL: o_dll_en stays 1, cap code holds. Exit only through the global override (drop i_cal_start).
- A single down-counter (width clog2 of the largest cycle parameter) is reused by RST, SETTLE and LOCKED. It is loaded on each state entry.
- i_bypass and i_cap_override are sampled only on IDLE exit, CHECK, and LOCKED loss. Changes at other times have no effect.
- Reset mid-operation: i_reset in any state returns all outputs to their reset values on the next edge.

Decomposition:
- Package aibio_dll_ctrl_pkg holds:
  - enum typedef dll_ctrl_state_e with the encodings above;
  - localparam CAP_W=5;
  - the relock counter width.
- One sub-module, aibio_dll_lock_sync: a 2-flop synchroniser with synchronous reset, used for i_dll_lock.

Test Plan:
(Bench parameters RESET_CYCLES=4, SETTLE_CYCLES=8, LOSS_CYCLES=4, CAP_START=0, CAP_MAX=31.)
- Nominal lock: start at cycle 0, i_dll_lock tied high -> RST at cycle 1, reset released at cycle 5, CHECK at cycle 13, o_cal_done=1 at cycle 14, capctrl=0.
- Sweep: i_dll_lock rises only once capctrl==7 has settled -> done with o_dll_capctrl=7. Exactly 8 reset pulses observed, each 4 cycles long.
- Sweep exhaustion: i_dll_lock=0 throughout -> capctrl steps 0..31 without wrap, then o_cal_fail=1 with capctrl=31. Dropping i_cal_start -> IDLE, o_dll_en=0.
- Loss of lock:
  - In LOCKED, a 3-cycle lock glitch -> stays LOCKED.
  - A 4-cycle drop (after sync delay) -> RST, o_relock_cnt=1, capctrl=0, then relocks.
  - 16 losses -> o_relock_cnt saturates at 15.
- Bypass: i_bypass=1, i_cap_override=19, lock high -> capctrl=19, done, no sweep. With lock low -> FAIL with capctrl=19.
- Abort and reset: i_pwrgood low during SETTLE -> IDLE next cycle, en=0, reset=1. i_reset during LOCKED -> all reset values, including capctrl=0 and relock_cnt=0.
